// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment codes, blank code, hold addresses and digit slots
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] HOLD1_ADDR = 8'd99;
    localparam logic [7:0] HOLD2_ADDR = 8'd199;

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2,
        DIG_SPARE = 2'd3
    } digit_e;

    // Active-low segments {dp,g,f,e,d,c,b,a}; non-decimal inputs render blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_dynamic.sv
// rtl/seg_dynamic.sv - 8-bit value to 3 blanked BCD digits, multiplexed over 4 digit positions
module seg_dynamic
    import seg_pkg::*;
#(
    parameter logic [15:0] SCAN_MAX = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] i_value,
    output logic [3:0] o_led_bit,
    output logic [7:0] o_led_out
);

    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_units;
    logic [7:0]  w_rem_h;
    logic [7:0]  r_code_h;
    logic [7:0]  r_code_t;
    logic [7:0]  r_code_u;
    logic [15:0] r_scan_cnt;
    logic        w_slot_end;
    digit_e      r_digit;
    digit_e      w_digit_next;
    logic [3:0]  r_led_bit;
    logic [7:0]  r_led_out;

    // Subtractive binary-to-BCD; the last matching multiple of ten wins.
    always_comb begin
        w_hund  = 4'd0;
        w_rem_h = i_value;
        if (i_value >= 8'd200) begin
            w_hund  = 4'd2;
            w_rem_h = i_value - 8'd200;
        end else if (i_value >= 8'd100) begin
            w_hund  = 4'd1;
            w_rem_h = i_value - 8'd100;
        end
        w_tens  = 4'd0;
        w_units = w_rem_h[3:0];
        for (int k = 1; k <= 9; k++) begin
            if (w_rem_h >= 8'(10 * k)) begin
                w_tens  = 4'(k);
                w_units = 4'(w_rem_h - 8'(10 * k));
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_code_h <= SEG_BLANK;
            r_code_t <= SEG_BLANK;
            r_code_u <= SEG_BLANK;
        end else begin
            r_code_h <= (w_hund == 4'd0) ? SEG_BLANK : seg_encode(w_hund);
            r_code_t <= (w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : seg_encode(w_tens);
            r_code_u <= seg_encode(w_units);
        end
    end

    assign w_slot_end = (r_scan_cnt == SCAN_MAX);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_scan_cnt <= 16'd0;
            r_digit    <= DIG_UNITS;
        end else begin
            r_scan_cnt <= w_slot_end ? 16'd0 : r_scan_cnt + 16'd1;
            r_digit    <= w_digit_next;
        end
    end

    always_comb begin
        w_digit_next = r_digit;
        if (w_slot_end) begin
            case (r_digit)
                DIG_UNITS: w_digit_next = DIG_TENS;
                DIG_TENS:  w_digit_next = DIG_HUNDS;
                DIG_HUNDS: w_digit_next = DIG_SPARE;
                default:   w_digit_next = DIG_UNITS;
            endcase
        end
    end

    // Select and segments are registered together so they always change in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_led_bit <= 4'b1111;
            r_led_out <= SEG_BLANK;
        end else begin
            case (r_digit)
                DIG_UNITS: begin r_led_bit <= 4'b1110; r_led_out <= r_code_u;  end
                DIG_TENS:  begin r_led_bit <= 4'b1101; r_led_out <= r_code_t;  end
                DIG_HUNDS: begin r_led_bit <= 4'b1011; r_led_out <= r_code_h;  end
                default:   begin r_led_bit <= 4'b0111; r_led_out <= SEG_BLANK; end
            endcase
        end
    end

    assign o_led_bit = r_led_bit;
    assign o_led_out = r_led_out;

endmodule

// File: rtl/rom_seg_top.sv
// rtl/rom_seg_top.sv - identity ROM swept by a timed address, with two key-selected hold addresses
module rom_seg_top
    import seg_pkg::*;
#(
    parameter logic [23:0] CNT_MAX  = 24'd9_999_999,
    parameter logic [15:0] SCAN_MAX = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key1,
    input  logic       key2,
    output logic [3:0] led_bit,
    output logic [7:0] led_out
);

    logic [23:0] r_cnt;
    logic [7:0]  r_addr_auto;
    logic        r_key1_d;
    logic        r_key2_d;
    logic        r_hold1;
    logic        r_hold2;
    logic [7:0]  r_rom_data;
    logic        w_key1_rise;
    logic        w_key2_rise;
    logic [7:0]  w_rom_addr;
    logic [7:0]  w_rom [256];

    always_comb begin
        for (int i = 0; i < 256; i++) begin
            w_rom[i] = 8'(i);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt       <= 24'd0;
            r_addr_auto <= 8'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt       <= 24'd0;
            r_addr_auto <= r_addr_auto + 8'd1;
        end else begin
            r_cnt       <= r_cnt + 24'd1;
        end
    end

    assign w_key1_rise = key1 & ~r_key1_d;
    assign w_key2_rise = key2 & ~r_key2_d;

    // key1 is checked first so a simultaneous press resolves in its favour.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_key1_d <= 1'b0;
            r_key2_d <= 1'b0;
            r_hold1  <= 1'b0;
            r_hold2  <= 1'b0;
        end else begin
            r_key1_d <= key1;
            r_key2_d <= key2;
            if (w_key1_rise) begin
                r_hold1 <= ~r_hold1;
                r_hold2 <= 1'b0;
            end else if (w_key2_rise) begin
                r_hold2 <= ~r_hold2;
                r_hold1 <= 1'b0;
            end
        end
    end

    assign w_rom_addr = r_hold1 ? HOLD1_ADDR :
                        r_hold2 ? HOLD2_ADDR : r_addr_auto;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rom_data <= 8'd0;
        end else begin
            r_rom_data <= w_rom[w_rom_addr];
        end
    end

    seg_dynamic #(
        .SCAN_MAX (SCAN_MAX)
    ) u_seg_dynamic (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i_value   (r_rom_data),
        .o_led_bit (led_bit),
        .o_led_out (led_out)
    );

endmodule

// File: tb/tb_rom_seg_top.sv
// tb/tb_rom_seg_top.sv - directed self-checking bench for rom_seg_top
module tb_rom_seg_top;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key1    = 1'b0;
    logic       key2    = 1'b0;
    logic [3:0] led_bit;
    logic [7:0] led_out;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_cnt  = 24'd0;
    logic [7:0]  m_addr = 8'd0;

    rom_seg_top #(
        .CNT_MAX  (24'd99),
        .SCAN_MAX (16'd3)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key1    (key1),
        .key2    (key2),
        .led_bit (led_bit),
        .led_out (led_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference timebase: address steps every 100 clocks.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_cnt  <= 24'd0;
            m_addr <= 8'd0;
        end else if (m_cnt == 24'd99) begin
            m_cnt  <= 24'd0;
            m_addr <= m_addr + 8'd1;
        end else begin
            m_cnt  <= m_cnt + 24'd1;
        end
    end

    function automatic logic [7:0] tb_seg(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] tb_disp(input int v);
        int h, t, u;
        logic [31:0] r;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        r[31:24] = 8'hFF;
        r[23:16] = (h == 0) ? 8'hFF : tb_seg(h);
        r[15:8]  = (h == 0 && t == 0) ? 8'hFF : tb_seg(t);
        r[7:0]   = tb_seg(u);
        return r;
    endfunction

    task automatic capture(output logic [31:0] disp, output logic [3:0] seen, output logic bad);
        disp = '1;
        seen = 4'b0000;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            case (led_bit)
                4'b1110: begin disp[7:0]   = led_out; seen[0] = 1'b1; end
                4'b1101: begin disp[15:8]  = led_out; seen[1] = 1'b1; end
                4'b1011: begin disp[23:16] = led_out; seen[2] = 1'b1; end
                4'b0111: begin disp[31:24] = led_out; seen[3] = 1'b1; end
                default: bad = 1'b1;
            endcase
        end
    endtask

    task automatic wait_model(input logic [7:0] a, input bit any_addr, input int budget,
                              output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if ((any_addr || m_addr == a) && m_cnt == 24'd10) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse(input logic k1, input logic k2);
        @(negedge sys_clk);
        key1 = k1;
        key2 = k2;
        @(negedge sys_clk);
        key1 = 1'b0;
        key2 = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (led_bit !== 4'b1111) begin
            errors++;
            $display("FAIL reset_led_bit got %b want 1111", led_bit);
        end
        checks++;
        if (led_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_led_out got %h want ff", led_out);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] exp;
        for (int k = 0; k < 16; k++) begin
            @(negedge sys_clk);
            exp = ~(4'b0001 << (k / 4));
            checks++;
            if (led_bit !== exp) begin
                errors++;
                $display("FAIL scan_cycle%0d got %b want %b", k, led_bit, exp);
            end
        end
    endtask

    task automatic test_auto;
        logic [31:0] d;
        logic [3:0]  s;
        logic        b;
        logic        ok;
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFFF_FFC0 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL auto_zero got %h seen %b bad %0d want ffffffc0 seen 1111", d, s, b);
        end
        wait_model(8'd1, 1'b0, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL auto_one_wait got timeout want addr 1");
        end
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFFF_FFF9 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL auto_one got %h seen %b bad %0d want fffffff9 seen 1111", d, s, b);
        end
    endtask

    task automatic test_key1_hold;
        logic [31:0] d, exp;
        logic [3:0]  s;
        logic        b, ok;
        pulse(1'b1, 1'b0);
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFFF_9090 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL key1_hold got %h seen %b bad %0d want ffff9090", d, s, b);
        end
        pulse(1'b1, 1'b0);
        wait_model(8'd0, 1'b1, 200, ok);
        exp = tb_disp(int'(m_addr));
        capture(d, s, b);
        checks++;
        if (!ok || d !== exp || s !== 4'hF || b) begin
            errors++;
            $display("FAIL key1_release got %h ok %0d want %h", d, ok, exp);
        end
    endtask

    task automatic test_key2_hold;
        logic [31:0] d;
        logic [3:0]  s;
        logic        b;
        pulse(1'b0, 1'b1);
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFF9_9090 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL key2_hold got %h seen %b bad %0d want fff99090", d, s, b);
        end
        pulse(1'b1, 1'b0);
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFFF_9090 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL key1_over_key2 got %h seen %b bad %0d want ffff9090", d, s, b);
        end
    endtask

    task automatic test_key_level;
        logic [31:0] d, exp;
        logic [3:0]  s;
        logic        b, ok;
        @(negedge sys_clk);
        key1 = 1'b1;
        repeat (6) @(negedge sys_clk);
        key1 = 1'b0;
        wait_model(8'd0, 1'b1, 200, ok);
        exp = tb_disp(int'(m_addr));
        capture(d, s, b);
        checks++;
        if (!ok || d !== exp || s !== 4'hF || b) begin
            errors++;
            $display("FAIL key_level got %h ok %0d want %h", d, ok, exp);
        end
    endtask

    task automatic test_simultaneous_and_reset;
        logic [31:0] d;
        logic [3:0]  s;
        logic        b, ok;
        pulse(1'b1, 1'b1);
        capture(d, s, b);
        checks++;
        if (d !== 32'hFFFF_9090 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL simultaneous got %h seen %b bad %0d want ffff9090", d, s, b);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        key2    = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (led_bit !== 4'b1111 || led_out !== 8'hFF) begin
            errors++;
            $display("FAIL midrun_reset got %b/%h want 1111/ff", led_bit, led_out);
        end
        sys_rst = 1'b0;
        key2    = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (led_bit !== 4'b1110) begin
            errors++;
            $display("FAIL first_slot got %b want 1110", led_bit);
        end
        wait_model(8'd0, 1'b0, 50, ok);
        capture(d, s, b);
        checks++;
        if (!ok || d !== 32'hFFFF_FFC0 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL after_reset got %h ok %0d want ffffffc0", d, ok);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic [3:0]  s;
        logic        b, ok;
        wait_model(8'd255, 1'b0, 26000, ok);
        capture(d, s, b);
        checks++;
        if (!ok || d !== 32'hFFA4_9292 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL addr_255 got %h ok %0d want ffa49292", d, ok);
        end
        wait_model(8'd0, 1'b0, 200, ok);
        capture(d, s, b);
        checks++;
        if (!ok || d !== 32'hFFFF_FFC0 || s !== 4'hF || b) begin
            errors++;
            $display("FAIL wrap_zero got %h ok %0d want ffffffc0", d, ok);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_auto();
        test_key1_hold();
        test_key2_hold();
        test_key_level();
        test_simultaneous_and_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_seg_top.md
ROM_SEG_TOP -- requirements
Module: rom_seg_top

Interface
REQ-001 Parameter CNT_MAX, 24 bit, default 24'd9_999_999: the address auto-advances once every CNT_MAX+1 clocks (200 ms at 50 MHz).
REQ-002 Parameter SCAN_MAX, 16 bit, default 16'd49_999: each display digit is held for SCAN_MAX+1 clocks (1 ms at 50 MHz).
REQ-003 sys_clk  input  1  single system clock; all logic rises on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 key1  input  1  pre-debounced key, active-high; a press is a 0->1 transition.
REQ-006 key2  input  1  pre-debounced key, active-high; a press is a 0->1 transition.
REQ-007 led_bit  output  4  digit select, active-low, one-hot-zero; bit 0 is the rightmost digit.
REQ-008 led_out  output  8  segment drive, active-low, order {dp,g,f,e,d,c,b,a}.

Function
REQ-009 Internal ROM SHALL be 256 x 8, contents rom[i] = i; read is registered with 1-clock latency.
REQ-010 Divider cnt SHALL count 0..CNT_MAX and then wrap to 0; addr_auto (8 bit) increments when cnt == CNT_MAX, wrapping 255 -> 0.
REQ-011 Key presses SHALL be detected on the rising edge using a 1-clock-delayed copy of the key; a level held high counts as one press.
REQ-012 hold1/hold2 flags: a key1 press toggles hold1 and clears hold2; a key2 press toggles hold2 and clears hold1.
REQ-013 Simultaneous key1 and key2 press in the same cycle: key1 wins (toggle hold1, clear hold2).
REQ-014 ROM address SHALL be 8'd99 when hold1 = 1, 8'd199 when hold2 = 1, and addr_auto otherwise.
REQ-015 addr_auto SHALL keep advancing while either hold is active; releasing a hold resumes at the current addr_auto.
REQ-016 ROM data SHALL be converted to 3 BCD digits (hundreds, tens, units); digit 3 is always blank.
REQ-017 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens are both 0; units always shown.
REQ-018 Segment codes for 0-9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex); blank = FF; dp is always off.
REQ-019 Scan sequence: led_bit steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_MAX+1 clocks; led_out carries the code of the selected digit in the same cycle.
REQ-020 Display latency from a ROM data change to updated segments SHALL be at most 3 clocks plus the current scan slot.

Reset
REQ-021 On sys_rst = 1 at a clock edge: cnt = 0, addr_auto = 0, hold1 = hold2 = 0, key delay registers = 0, scan counter = 0, digit index = 0, ROM output register = 0, led_bit = 4'b1111, led_out = 8'hFF.
REQ-022 Reset asserted mid-operation SHALL override key presses and counter wraps in the same cycle.
REQ-023 First scan slot after reset release SHALL be led_bit = 1110.

Structure
REQ-024 Shared package seg_pkg SHALL hold the 7-segment code constants, the blank code, and the fixed hold addresses (99, 199).
REQ-025 Exactly one sub-module, seg_dynamic: 8-bit value in, led_bit/led_out out (BCD conversion, blanking, scan); ROM, divider and key logic stay in the top level.

Verification
REQ-026 CNT_MAX = 99, no keys: addr_auto 0 -> 1 after 100 clocks; display shows "1" (units 0xF9, other digits FF) within one full scan.
REQ-027 CNT_MAX = 99, key1 1-clock pulse -> display shows 99 (0x90, 0x90, FF, FF); second key1 pulse -> auto value resumes.
REQ-028 key2 pulse -> display 199 (units 0x90, tens 0x90, hundreds 0xF9); key1 pulse while hold2 is active -> 99 shown.
REQ-029 Run addr_auto past 255 -> wraps to 0, display shows "0" (units 0xC0, others FF).
REQ-030 key1 and key2 pulsed in the same cycle -> hold1 = 1, hold2 = 0, display 99; sys_rst pulse -> led_bit = 1111, led_out = FF next cycle, then addr 0.
